hazard_ctrl: RTL and testbench

Pipeline sequencing controller for the 16-bit five-stage MIPS core. It sits beside the IF_ID, ID_EX and EX_MEM registers and the Fetch stage.
- Detects load-use hazards and inserts bubbles.
- Flushes wrong-path instructions on a taken branch.
- Freezes the whole pipeline while data memory is not ready; a watchdog traps a hung memory.
- Owns the pc_write, register-enable and flush strobes for those registers.

---
 rtl/mips_pkg.sv | 50 +++++
 rtl/mem_watchdog.sv | 53 +++++
 rtl/hazard_ctrl.sv | 173 +++++++++++++++++
 tb/tb_hazard_ctrl.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: shared types and constants for the 16-bit five-stage MIPS pipeline
// control. Holds the hazard controller state encoding, instruction field
// positions, register address width and the canned strobe sets that the
// hazard controller drives onto the PC / IF_ID / ID_EX / EX_MEM registers.
package mips_pkg;

  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_LOAD_STALL = 2'd1,
    ST_MEM_WAIT   = 2'd2,
    ST_ERROR      = 2'd3
  } state_e;

  // Instruction field MSB positions (rs = [12:10], rt = [9:7], rd = [6:4]).
  localparam int unsigned RS_MSB       = 12;
  localparam int unsigned RT_MSB       = 9;
  localparam int unsigned RD_MSB       = 6;
  localparam int unsigned REG_ADDR_W   = 3;

  localparam int unsigned WAIT_CNT_W   = 8;
  localparam int unsigned BUBBLE_CNT_W = 2;
  localparam int unsigned PERF_CNT_W   = 16;

  // Pipeline strobe bundle driven by the hazard controller.
  typedef struct packed {
    logic pc_write;
    logic ifid_write;
    logic ifid_flush;
    logic idex_flush;
    logic exmem_flush;
    logic pipe_hold;
  } ctrl_t;

  // Free-running pipeline.
  localparam ctrl_t CTRL_DEFAULT = '{pc_write: 1'b1, ifid_write: 1'b1, ifid_flush: 1'b0,
                                     idex_flush: 1'b0, exmem_flush: 1'b0, pipe_hold: 1'b0};
  // Reset: freeze fetch, clear every stage to NOP.
  localparam ctrl_t CTRL_RESET   = '{pc_write: 1'b0, ifid_write: 1'b0, ifid_flush: 1'b1,
                                     idex_flush: 1'b1, exmem_flush: 1'b1, pipe_hold: 1'b0};
  // Load-use bubble: hold PC and IF_ID, inject a bubble into ID_EX.
  localparam ctrl_t CTRL_STALL   = '{pc_write: 1'b0, ifid_write: 1'b0, ifid_flush: 1'b0,
                                     idex_flush: 1'b1, exmem_flush: 1'b0, pipe_hold: 1'b0};
  // Taken branch: load target into PC, squash the three wrong-path stages.
  localparam ctrl_t CTRL_FLUSH   = '{pc_write: 1'b1, ifid_write: 1'b1, ifid_flush: 1'b1,
                                     idex_flush: 1'b1, exmem_flush: 1'b1, pipe_hold: 1'b0};
  // Memory wait / error: freeze everything.
  localparam ctrl_t CTRL_HOLD    = '{pc_write: 1'b0, ifid_write: 1'b0, ifid_flush: 1'b0,
                                     idex_flush: 1'b0, exmem_flush: 1'b0, pipe_hold: 1'b1};

endpackage

// File: rtl/mem_watchdog.sv
// mem_watchdog: counts consecutive data-memory wait cycles and flags a hung
// memory.
//   clk, rst      : clock, synchronous active-high reset
//   start         : first held cycle of a memory wait (loads count with 1)
//   in_wait       : controller is in MEM_WAIT
//   dmem_ready    : memory completes the access this cycle
//   timeout_c     : combinational, limit reached while still not ready
//   mem_err       : sticky error flag, cleared only by rst
module mem_watchdog
  import mips_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic in_wait,
  input  logic dmem_ready,
  output logic timeout_c,
  output logic mem_err
);

  logic [WAIT_CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic                  mem_err_q, mem_err_d;

  // Ready on the limit cycle wins over the timeout.
  assign timeout_c = in_wait & ~dmem_ready & (wait_cnt_q == WAIT_CNT_W'(MEM_TIMEOUT));

  // Wait counter and sticky error next-state.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    mem_err_d  = mem_err_q | timeout_c;
    if (start) begin
      wait_cnt_d = WAIT_CNT_W'(1);
    end else if (in_wait) begin
      if (dmem_ready) wait_cnt_d = '0;
      else            wait_cnt_d = wait_cnt_q + WAIT_CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt_q <= '0;
      mem_err_q  <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      mem_err_q  <= mem_err_d;
    end
  end

  assign mem_err = mem_err_q;

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline sequencing controller for the five-stage MIPS core.
// Detects load-use hazards (bubbles), flushes wrong-path work on a taken
// branch, freezes the pipe during data-memory waits and traps a hung memory.
//   Inputs : clk, rst (sync, active-high), ifid_rs/ifid_rt/ifid_uses_rt,
//            idex_mem_read/idex_rt, branch_taken, dmem_req, dmem_ready
//   Outputs: pc_write, ifid_write, ifid_flush, idex_flush, exmem_flush,
//            pipe_hold (combinational from state + inputs), mem_err (sticky)
// Optional: define HAZARD_PERF_CNT_EN to add saturating 16-bit counters
//           stall_cycles, flush_events and memwait_cycles.
module hazard_ctrl
  import mips_pkg::*;
#(
  parameter int unsigned LOAD_BUBBLES = 1,
  parameter int unsigned MEM_TIMEOUT  = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] ifid_rs,
  input  logic [REG_ADDR_W-1:0] ifid_rt,
  input  logic                  ifid_uses_rt,
  input  logic                  idex_mem_read,
  input  logic [REG_ADDR_W-1:0] idex_rt,
  input  logic                  branch_taken,
  input  logic                  dmem_req,
  input  logic                  dmem_ready,
  output logic                  pc_write,
  output logic                  ifid_write,
  output logic                  ifid_flush,
  output logic                  idex_flush,
  output logic                  exmem_flush,
  output logic                  pipe_hold,
  output logic                  mem_err
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [15:0]           stall_cycles,
  output logic [15:0]           flush_events,
  output logic [15:0]           memwait_cycles
`endif
);

  state_e                  state_q, state_d;
  state_e                  ret_state_q, ret_state_d;
  logic [BUBBLE_CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;
  ctrl_t                   ctrl;
  logic                    load_use_c;
  logic                    mem_wait_c;
  logic                    wd_start;
  logic                    wd_timeout_c;

  // $0 is deliberately not excluded: a conservative stall is acceptable.
  assign load_use_c = idex_mem_read &
                      ((idex_rt == ifid_rs) | (ifid_uses_rt & (idex_rt == ifid_rt)));
  assign mem_wait_c = dmem_req & ~dmem_ready;

  // Next-state and strobe decode; mem wait > branch > load-use.
  always_comb begin
    ctrl         = CTRL_DEFAULT;
    state_d      = state_q;
    ret_state_d  = ret_state_q;
    bubble_cnt_d = bubble_cnt_q;
    wd_start     = 1'b0;
    unique case (state_q)
      ST_RUN, ST_LOAD_STALL: begin
        if (mem_wait_c) begin
          // Pending bubbles survive the wait and resume afterwards.
          ctrl        = CTRL_HOLD;
          state_d     = ST_MEM_WAIT;
          ret_state_d = state_q;
          wd_start    = 1'b1;
        end else if (branch_taken) begin
          ctrl         = CTRL_FLUSH;
          state_d      = ST_RUN;
          bubble_cnt_d = '0;
        end else if (state_q == ST_LOAD_STALL) begin
          ctrl         = CTRL_STALL;
          bubble_cnt_d = bubble_cnt_q - BUBBLE_CNT_W'(1);
          state_d      = (bubble_cnt_q > BUBBLE_CNT_W'(1)) ? ST_LOAD_STALL : ST_RUN;
        end else if (load_use_c) begin
          ctrl = CTRL_STALL;
          if (LOAD_BUBBLES > 1) begin
            state_d      = ST_LOAD_STALL;
            bubble_cnt_d = BUBBLE_CNT_W'(LOAD_BUBBLES - 1);
          end
        end
      end
      ST_MEM_WAIT: begin
        if (dmem_ready) begin
          state_d = ret_state_q;
        end else begin
          ctrl = CTRL_HOLD;
          if (wd_timeout_c) state_d = ST_ERROR;
        end
      end
      ST_ERROR: begin
        ctrl = CTRL_HOLD;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
    if (rst) ctrl = CTRL_RESET;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_RUN;
      ret_state_q  <= ST_RUN;
      bubble_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      ret_state_q  <= ret_state_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  mem_watchdog #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_mem_watchdog (
    .clk       (clk),
    .rst       (rst),
    .start     (wd_start),
    .in_wait   (state_q == ST_MEM_WAIT),
    .dmem_ready(dmem_ready),
    .timeout_c (wd_timeout_c),
    .mem_err   (mem_err)
  );

  assign pc_write    = ctrl.pc_write;
  assign ifid_write  = ctrl.ifid_write;
  assign ifid_flush  = ctrl.ifid_flush;
  assign idex_flush  = ctrl.idex_flush;
  assign exmem_flush = ctrl.exmem_flush;
  assign pipe_hold   = ctrl.pipe_hold;

`ifdef HAZARD_PERF_CNT_EN
  logic [PERF_CNT_W-1:0] stall_cycles_q, stall_cycles_d;
  logic [PERF_CNT_W-1:0] flush_events_q, flush_events_d;
  logic [PERF_CNT_W-1:0] memwait_cycles_q, memwait_cycles_d;
  logic                  stall_ev, flush_ev, hold_ev;

  // A bubble is idex_flush without the branch squash of EX_MEM.
  assign stall_ev = ~rst & ctrl.idex_flush & ~ctrl.exmem_flush;
  assign flush_ev = ~rst & ctrl.exmem_flush;
  assign hold_ev  = ~rst & ctrl.pipe_hold;

  // Saturating event counters.
  always_comb begin
    stall_cycles_d   = stall_cycles_q;
    flush_events_d   = flush_events_q;
    memwait_cycles_d = memwait_cycles_q;
    if (stall_ev && (stall_cycles_q != '1))   stall_cycles_d   = stall_cycles_q + PERF_CNT_W'(1);
    if (flush_ev && (flush_events_q != '1))   flush_events_d   = flush_events_q + PERF_CNT_W'(1);
    if (hold_ev && (memwait_cycles_q != '1))  memwait_cycles_d = memwait_cycles_q + PERF_CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles_q   <= '0;
      flush_events_q   <= '0;
      memwait_cycles_q <= '0;
    end else begin
      stall_cycles_q   <= stall_cycles_d;
      flush_events_q   <= flush_events_d;
      memwait_cycles_q <= memwait_cycles_d;
    end
  end

  assign stall_cycles   = stall_cycles_q;
  assign flush_events   = flush_events_q;
  assign memwait_cycles = memwait_cycles_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed, table-driven bench for hazard_ctrl. Two instances
// (LOAD_BUBBLES=1 and 2) share the stimulus; each row is one clock cycle and
// carries the hand-computed strobes expected from each instance.
module tb_hazard_ctrl;

  // Expected output packing: {pc_write, ifid_write, ifid_flush, idex_flush,
  //                           exmem_flush, pipe_hold, mem_err}
  localparam logic [6:0] O_DEF   = 7'b1100000;
  localparam logic [6:0] O_RST   = 7'b0011100;
  localparam logic [6:0] O_STALL = 7'b0001000;
  localparam logic [6:0] O_FLUSH = 7'b1111100;
  localparam logic [6:0] O_HOLD  = 7'b0000010;
  localparam logic [6:0] O_ERR   = 7'b0000011;
  localparam logic [6:0] O_RSTE  = 7'b0011101;

  typedef struct {
    logic       rst;
    logic [2:0] rs;
    logic [2:0] rt;
    logic       uses_rt;
    logic       mem_read;
    logic [2:0] idex_rt;
    logic       branch;
    logic       req;
    logic       ready;
    logic [6:0] exp1;
    logic [6:0] exp2;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] ifid_rs, ifid_rt, idex_rt;
  logic       ifid_uses_rt, idex_mem_read, branch_taken, dmem_req, dmem_ready;

  logic pcw1, ifw1, iff1, idf1, exf1, hold1, err1;
  logic pcw2, ifw2, iff2, idf2, exf2, hold2, err2;
  logic [6:0] o1, o2;

  int checks = 0;
  int errors = 0;

`ifdef HAZARD_PERF_CNT_EN
  logic [15:0] sc1, fe1, mw1, sc2, fe2, mw2;
`endif

  always #5 clk = ~clk;

  hazard_ctrl #(.LOAD_BUBBLES(1), .MEM_TIMEOUT(15)) u_dut1 (
    .clk(clk), .rst(rst), .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
    .ifid_uses_rt(ifid_uses_rt), .idex_mem_read(idex_mem_read), .idex_rt(idex_rt),
    .branch_taken(branch_taken), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .pc_write(pcw1), .ifid_write(ifw1), .ifid_flush(iff1), .idex_flush(idf1),
    .exmem_flush(exf1), .pipe_hold(hold1), .mem_err(err1)
`ifdef HAZARD_PERF_CNT_EN
    , .stall_cycles(sc1), .flush_events(fe1), .memwait_cycles(mw1)
`endif
  );

  hazard_ctrl #(.LOAD_BUBBLES(2), .MEM_TIMEOUT(15)) u_dut2 (
    .clk(clk), .rst(rst), .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
    .ifid_uses_rt(ifid_uses_rt), .idex_mem_read(idex_mem_read), .idex_rt(idex_rt),
    .branch_taken(branch_taken), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .pc_write(pcw2), .ifid_write(ifw2), .ifid_flush(iff2), .idex_flush(idf2),
    .exmem_flush(exf2), .pipe_hold(hold2), .mem_err(err2)
`ifdef HAZARD_PERF_CNT_EN
    , .stall_cycles(sc2), .flush_events(fe2), .memwait_cycles(mw2)
`endif
  );

  assign o1 = {pcw1, ifw1, iff1, idf1, exf1, hold1, err1};
  assign o2 = {pcw2, ifw2, iff2, idf2, exf2, hold2, err2};

  function automatic vec_t mk(input logic r, input logic [2:0] rs, input logic [2:0] rt,
                              input logic ur, input logic mr, input logic [2:0] xrt,
                              input logic br, input logic rq, input logic rd,
                              input logic [6:0] e1, input logic [6:0] e2);
    vec_t v;
    v.rst = r; v.rs = rs; v.rt = rt; v.uses_rt = ur; v.mem_read = mr;
    v.idex_rt = xrt; v.branch = br; v.req = rq; v.ready = rd;
    v.exp1 = e1; v.exp2 = e2;
    return v;
  endfunction

  // Drive one cycle's inputs after the falling edge, check before the rising edge.
  task automatic run(input vec_t v, input string name);
    @(negedge clk);
    rst = v.rst; ifid_rs = v.rs; ifid_rt = v.rt; ifid_uses_rt = v.uses_rt;
    idex_mem_read = v.mem_read; idex_rt = v.idex_rt; branch_taken = v.branch;
    dmem_req = v.req; dmem_ready = v.ready;
    #2;
    checks++;
    if (o1 !== v.exp1) begin
      errors++;
      $display("FAIL %s lb1: got %b expected %b", name, o1, v.exp1);
    end
    checks++;
    if (o2 !== v.exp2) begin
      errors++;
      $display("FAIL %s lb2: got %b expected %b", name, o2, v.exp2);
    end
  endtask

  vec_t tbl[23];
  vec_t idle;

  initial begin
    rst = 1'b1; ifid_rs = '0; ifid_rt = '0; ifid_uses_rt = 1'b0; idex_mem_read = 1'b0;
    idex_rt = '0; branch_taken = 1'b0; dmem_req = 1'b0; dmem_ready = 1'b0;
    idle = mk(0, 3'd1, 3'd2, 1, 0, 3'd3, 0, 0, 0, O_DEF, O_DEF);

    //            rst rs    rt    ur mr idexrt br rq rd  exp1     exp2
    tbl[0]  = mk(1, 3'd1, 3'd2, 0, 0, 3'd3, 0, 0, 0, O_RST,   O_RST);
    tbl[1]  = mk(1, 3'd1, 3'd2, 0, 0, 3'd3, 0, 0, 0, O_RST,   O_RST);
    tbl[2]  = mk(0, 3'd1, 3'd2, 1, 0, 3'd3, 0, 0, 0, O_DEF,   O_DEF);
    tbl[3]  = mk(0, 3'd3, 3'd2, 0, 1, 3'd3, 0, 0, 0, O_STALL, O_STALL);  // rs hazard
    tbl[4]  = mk(0, 3'd3, 3'd2, 0, 0, 3'd3, 0, 0, 0, O_DEF,   O_STALL);  // second bubble only LB=2
    tbl[5]  = mk(0, 3'd1, 3'd2, 1, 0, 3'd3, 0, 0, 0, O_DEF,   O_DEF);
    tbl[6]  = mk(0, 3'd0, 3'd5, 1, 1, 3'd5, 0, 0, 0, O_STALL, O_STALL);  // rt hazard
    tbl[7]  = mk(0, 3'd0, 3'd5, 1, 0, 3'd5, 0, 0, 0, O_DEF,   O_STALL);
    tbl[8]  = mk(0, 3'd1, 3'd5, 0, 1, 3'd5, 0, 0, 0, O_DEF,   O_DEF);    // rt not a source
    tbl[9]  = mk(0, 3'd0, 3'd6, 0, 1, 3'd0, 0, 0, 0, O_STALL, O_STALL);  // $0 still stalls
    tbl[10] = mk(0, 3'd0, 3'd6, 0, 0, 3'd0, 0, 0, 0, O_DEF,   O_STALL);
    tbl[11] = mk(0, 3'd3, 3'd2, 0, 1, 3'd3, 1, 0, 0, O_FLUSH, O_FLUSH);  // branch beats load-use
    tbl[12] = mk(0, 3'd1, 3'd2, 1, 0, 3'd3, 0, 0, 0, O_DEF,   O_DEF);
    tbl[13] = mk(0, 3'd3, 3'd2, 0, 1, 3'd3, 0, 0, 0, O_STALL, O_STALL);
    tbl[14] = mk(0, 3'd1, 3'd2, 0, 0, 3'd3, 1, 0, 0, O_FLUSH, O_FLUSH);  // branch in LOAD_STALL
    tbl[15] = mk(0, 3'd1, 3'd2, 0, 0, 3'd3, 0, 0, 0, O_DEF,   O_DEF);    // bubble discarded
    tbl[16] = mk(0, 3'd3, 3'd2, 0, 1, 3'd3, 1, 1, 0, O_HOLD,  O_HOLD);   // mem wait beats all
    tbl[17] = mk(0, 3'd1, 3'd2, 0, 0, 3'd3, 0, 1, 0, O_HOLD,  O_HOLD);
    tbl[18] = mk(0, 3'd1, 3'd2, 0, 0, 3'd3, 0, 1, 0, O_HOLD,  O_HOLD);
    tbl[19] = mk(0, 3'd1, 3'd2, 0, 0, 3'd3, 0, 1, 0, O_HOLD,  O_HOLD);
    tbl[20] = mk(0, 3'd1, 3'd2, 0, 0, 3'd3, 0, 1, 1, O_DEF,   O_DEF);    // ready releases
    tbl[21] = mk(0, 3'd1, 3'd2, 0, 0, 3'd3, 0, 0, 0, O_DEF,   O_DEF);
    tbl[22] = mk(0, 3'd1, 3'd2, 0, 0, 3'd3, 0, 1, 1, O_DEF,   O_DEF);    // zero-wait access

    for (int i = 0; i < 23; i++) run(tbl[i], $sformatf("tbl%0d", i));

    // Watchdog: ready never rises; 16 held cycles (entry + 15 in MEM_WAIT), then ERROR.
    run(mk(1, 3'd1, 3'd2, 0, 0, 3'd3, 0, 0, 0, O_RST, O_RST), "to_rst");
    for (int k = 0; k < 16; k++)
      run(mk(0, 3'd1, 3'd2, 0, 0, 3'd3, 0, 1, 0, O_HOLD, O_HOLD), $sformatf("to_hold%0d", k));
    run(mk(0, 3'd1, 3'd2, 0, 0, 3'd3, 0, 1, 0, O_ERR, O_ERR), "to_err");
    run(mk(0, 3'd1, 3'd2, 0, 0, 3'd3, 0, 1, 1, O_ERR, O_ERR), "to_err_ready");
    run(mk(0, 3'd3, 3'd2, 0, 1, 3'd3, 1, 0, 0, O_ERR, O_ERR), "to_err_sticky");
    run(mk(1, 3'd1, 3'd2, 0, 0, 3'd3, 0, 0, 0, O_RSTE, O_RSTE), "to_rst_err");  // clears on clock
    run(idle, "to_after_rst");

    // Mem wait entered from LOAD_STALL resumes with exactly one further bubble.
    run(mk(1, 3'd1, 3'd2, 0, 0, 3'd3, 0, 0, 0, O_RST, O_RST), "ls_rst");
    run(mk(0, 3'd3, 3'd2, 0, 1, 3'd3, 0, 0, 0, O_STALL, O_STALL), "ls_hazard");
    run(mk(0, 3'd3, 3'd2, 0, 0, 3'd3, 0, 1, 0, O_HOLD, O_HOLD), "ls_wait0");
    run(mk(0, 3'd3, 3'd2, 0, 0, 3'd3, 0, 1, 0, O_HOLD, O_HOLD), "ls_wait1");
    run(mk(0, 3'd3, 3'd2, 0, 0, 3'd3, 0, 1, 1, O_DEF, O_DEF), "ls_ready");
    run(mk(0, 3'd3, 3'd2, 0, 0, 3'd3, 0, 0, 0, O_DEF, O_STALL), "ls_resume");
    run(idle, "ls_done");

    // Ready arriving on the limit cycle wins over the timeout.
    run(mk(1, 3'd1, 3'd2, 0, 0, 3'd3, 0, 0, 0, O_RST, O_RST), "lim_rst");
    for (int k = 0; k < 16; k++)
      run(mk(0, 3'd1, 3'd2, 0, 0, 3'd3, 0, 1, 0, O_HOLD, O_HOLD), $sformatf("lim_hold%0d", k));
    run(mk(1, 3'd1, 3'd2, 0, 0, 3'd3, 0, 0, 0, O_RSTE, O_RSTE), "lim_rst2");
    for (int k = 0; k < 15; k++)
      run(mk(0, 3'd1, 3'd2, 0, 0, 3'd3, 0, 1, 0, O_HOLD, O_HOLD), $sformatf("lim2_hold%0d", k));
    run(mk(0, 3'd1, 3'd2, 0, 0, 3'd3, 0, 1, 1, O_DEF, O_DEF), "lim2_ready");
    run(idle, "lim2_no_err");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
